ra_sample_tx: RTL and testbench
===============================

Name: ra_sample_tx

Overview:
- Transmit end of the sample interface (data strobe + 5-bit value) that feeds the rolling-average datapath.
- Buffers samples written by a local producer in a small FIFO.
- Replays each sample on o_data_clk / o_value with programmable setup, high and gap times, so the receiving shift-register line captures exactly one element per rising edge of o_data_clk.
- Sits in front of the shift_register_line input pins, or drives those io pins in a loopback test harness.

Parameters:
- BITS_PER_ELEM, 5, width of one sample.
- FIFO_DEPTH, 4, sample buffer entries; power of two, >= 2.
- SETUP_CYCLES, 1, clk cycles o_value is stable with o_data_clk low before the rise; >= 1.
- HIGH_CYCLES, 2, clk cycles o_data_clk is held high; >= 1.
- LOW_CYCLES, 2, clk cycles o_data_clk is low after the fall, before the next setup; >= 1.
- FILL_COUNT, 9, strobes per fill burst (window size + 1 stale element); used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low.
- i_wr_valid  input  1  producer offers i_wr_value this cycle.
- i_wr_value  input  BITS_PER_ELEM  sample to enqueue.
- o_wr_ready  output  1  FIFO can accept; combinational, equals (count != FIFO_DEPTH).
- o_data_clk  output  1  registered capture strobe; receiver samples on its rising edge.
- o_value  output  BITS_PER_ELEM  registered sample presented to the receiver.
- o_busy  output  1  high whenever the FSM is not in IDLE.
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, count=0, read/write pointers=0.
  - o_data_clk=0, o_value=0, o_busy=0; o_wr_ready=1 after reset.
  - Reset mid-strobe drops o_data_clk low at the next edge and discards all FIFO contents.
- Enqueue: when i_wr_valid && o_wr_ready at an edge, write the head and increment count.
  - Readiness is based on the pre-edge count, so a write attempted while full is ignored even if a pop occurs on that edge.
  - A push and a pop on the same edge leave count unchanged.
- FSM states, advanced by a cycle counter:
  - IDLE: if count>0, pop the FIFO head into o_value and go to SETUP; otherwise stay. o_data_clk=0.
  - SETUP: o_data_clk=0 for SETUP_CYCLES cycles, then o_data_clk<=1 and go to HIGH.
  - HIGH: o_data_clk=1 for HIGH_CYCLES cycles, then o_data_clk<=0 and go to GAP.
  - GAP: o_data_clk=0 for LOW_CYCLES cycles. At exit, if count>0, pop into o_value and go to SETUP; otherwise go to IDLE.
- o_value changes only on a pop. It holds through HIGH, GAP and IDLE, and is never modified while o_data_clk=1.
- Latency: a write accepted at edge E0 is popped at E1; o_data_clk rises at edge E1+SETUP_CYCLES.
- Back-to-back period: SETUP_CYCLES+HIGH_CYCLES+LOW_CYCLES cycles per sample (5 with defaults). There is no IDLE cycle between queued samples.
- Empty: the FSM parks in IDLE with o_data_clk=0. No spurious strobes are ever produced.
- Full: o_wr_ready=0 until the next pop.

Optional Feature:
- Macro RA_TX_FILL_EN.
- Defined:
  - Adds input port i_fill (1 bit).
  - A pulse on i_fill while the FSM is in IDLE and count==0 latches i_wr_value as the fill value. This does not enqueue it.
  - The block then emits FILL_COUNT strobes of that value using the normal SETUP/HIGH/GAP timing, which primes the averager window.
  - o_wr_ready=0 for the whole burst; i_fill is ignored at all other times.
  - After the burst, the FSM returns to IDLE.
- Undefined: the i_fill port and the fill counter are absent; behaviour is otherwise identical.

Test Plan:
All cases use default parameters.
- Reset with rst=0 for 2 cycles -> o_data_clk=0, o_value=0, o_busy=0, o_wr_ready=1, o_fifo_count=0.
- Single write of 5'd17 at edge E0 -> o_value=17 after E1; o_data_clk high after E2 and E3, low after E4; o_busy returns 0 after E6.
- Four writes 3,7,11,31 on consecutive cycles -> o_wr_ready stays 1 (one pop occurs during the burst). Exactly four o_data_clk rising edges, 5 cycles apart, with o_value 3,7,11,31 stable at each rise.
- Six writes with i_wr_valid held high -> o_wr_ready drops when count reaches 4. No values are lost or duplicated; the receiver model captures them in order.
- Assert rst while o_data_clk=1 with 2 entries queued -> o_data_clk=0 and o_fifo_count=0 after the next edge, and no further strobes occur.
- With RA_TX_FILL_EN defined, i_fill with i_wr_value=12 in IDLE -> exactly 9 rising edges, all with o_value=12, and o_wr_ready=0 throughout the burst.

Source files
------------

// File: rtl/ra_sample_tx.sv
// ra_sample_tx: FIFO-buffered sample replayer driving o_data_clk/o_value.
// Optional fill burst enabled by defining RA_TX_FILL_EN.
module ra_sample_tx #(
  parameter int BITS_PER_ELEM = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int HIGH_CYCLES   = 2,
  parameter int LOW_CYCLES    = 2,
  parameter int FILL_COUNT    = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_valid,
  input  logic [BITS_PER_ELEM-1:0]     i_wr_value,
`ifdef RA_TX_FILL_EN
  input  logic                         i_fill,
`endif
  output logic                         o_wr_ready,
  output logic                         o_data_clk,
  output logic [BITS_PER_ELEM-1:0]     o_value,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(SETUP_CYCLES + HIGH_CYCLES + LOW_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SETUP_CYCLES < 1 || HIGH_CYCLES < 1 || LOW_CYCLES < 1 ||
      FILL_COUNT < 1) begin : g_bad_params
    $error("ra_sample_tx: illegal parameter set");
  end

  logic [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic [CW-1:0]            count;
  logic [1:0]               state;
  logic [TW-1:0]            tcnt;
  logic [TW-1:0]            lim;
  logic                     last;
  logic                     has_data;
  logic                     push;
  logic                     pop;
  logic                     filling;
  logic                     fill_go;

`ifdef RA_TX_FILL_EN
  localparam int FW = $clog2(FILL_COUNT + 1);
  logic [FW-1:0] fill_left;
  logic          fill_on;

  assign filling = fill_on;
  assign fill_go = i_fill && (state == S_IDLE) && (count == '0);
`else
  assign filling = 1'b0;
  assign fill_go = 1'b0;
`endif

  assign has_data     = (count != '0);
  assign o_wr_ready   = (count != CW'(FIFO_DEPTH)) && !filling && !fill_go;
  assign push         = i_wr_valid && o_wr_ready;
  assign o_busy       = (state != S_IDLE);
  assign o_fifo_count = count;

  always_comb begin
    lim = '0;
    unique case (state)
      S_SETUP: lim = TW'(SETUP_CYCLES - 1);
      S_HIGH:  lim = TW'(HIGH_CYCLES - 1);
      S_GAP:   lim = TW'(LOW_CYCLES - 1);
      default: lim = '0;
    endcase
  end

  assign last = (tcnt == lim);

  // A pop happens on leaving IDLE or GAP; a fill burst never pops.
  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): pop = has_data && !fill_go;
      (state == S_GAP):  pop = has_data && last && !filling;
      default:           pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_wr_value;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      o_data_clk <= 1'b0;
      o_value    <= '0;
`ifdef RA_TX_FILL_EN
      fill_on    <= 1'b0;
      fill_left  <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          tcnt       <= '0;
          o_data_clk <= 1'b0;
          if (fill_go) begin
            o_value <= i_wr_value;
            state   <= S_SETUP;
`ifdef RA_TX_FILL_EN
            fill_on   <= 1'b1;
            fill_left <= FW'(FILL_COUNT - 1);
`endif
          end else if (pop) begin
            o_value <= mem[rptr];
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (last) begin
            tcnt       <= '0;
            o_data_clk <= 1'b1;
            state      <= S_HIGH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (last) begin
            tcnt       <= '0;
            o_data_clk <= 1'b0;
            state      <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          if (!last) begin
            tcnt <= tcnt + 1'b1;
          end else begin
            tcnt <= '0;
`ifdef RA_TX_FILL_EN
            if (fill_on) begin
              if (fill_left != '0) begin
                fill_left <= fill_left - 1'b1;
                state     <= S_SETUP;
              end else begin
                fill_on <= 1'b0;
                state   <= S_IDLE;
              end
            end else
`endif
            if (pop) begin
              o_value <= mem[rptr];
              state   <= S_SETUP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ra_sample_tx.sv
// Directed bench for ra_sample_tx with a strobe-capturing receiver model.
// Fill-burst case runs only when RA_TX_FILL_EN is defined.
module tb_ra_sample_tx;

  logic       clk;
  logic       rst;
  logic       i_wr_valid;
  logic [4:0] i_wr_value;
`ifdef RA_TX_FILL_EN
  logic       i_fill;
`endif
  logic       o_wr_ready;
  logic       o_data_clk;
  logic [4:0] o_value;
  logic       o_busy;
  logic [2:0] o_fifo_count;

  int compared;
  int mismatched;

  logic [4:0] cap[$];
  time        rise_t[$];

  ra_sample_tx dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_valid   (i_wr_valid),
    .i_wr_value   (i_wr_value),
`ifdef RA_TX_FILL_EN
    .i_fill       (i_fill),
`endif
    .o_wr_ready   (o_wr_ready),
    .o_data_clk   (o_data_clk),
    .o_value      (o_value),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: one capture per rising edge of the strobe.
  always @(posedge o_data_clk) begin
    cap.push_back(o_value);
    rise_t.push_back($time);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(input logic [4:0] v, output int stalls);
    stalls = 0;
    i_wr_valid = 1'b1;
    i_wr_value = v;
    while (!o_wr_ready && stalls < 50) begin
      tick();
      stalls++;
    end
    tick();
    i_wr_valid = 1'b0;
  endtask

  logic [4:0] vals4 [4];
  logic [4:0] vals6 [6];
  int         st;
  int         saw_full;
  int         n0;
`ifdef RA_TX_FILL_EN
  int         ready_hi;
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    vals4 = '{5'd3, 5'd7, 5'd11, 5'd31};
    vals6 = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd21};
    rst        = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_value = '0;
`ifdef RA_TX_FILL_EN
    i_fill     = 1'b0;
`endif

    // Reset
    tick();
    tick();
    chk("rst_dclk",  o_data_clk,   0);
    chk("rst_value", o_value,      0);
    chk("rst_busy",  o_busy,       0);
    chk("rst_ready", o_wr_ready,   1);
    chk("rst_count", o_fifo_count, 0);
    rst = 1'b1;
    tick();

    // Single write of 17
    cap.delete();
    i_wr_valid = 1'b1;
    i_wr_value = 5'd17;
    tick();
    i_wr_valid = 1'b0;
    chk("e0_count", o_fifo_count, 1);
    chk("e0_busy",  o_busy,       0);
    tick();
    chk("e1_value", o_value,      17);
    chk("e1_dclk",  o_data_clk,   0);
    chk("e1_busy",  o_busy,       1);
    chk("e1_count", o_fifo_count, 0);
    tick();
    chk("e2_dclk",  o_data_clk,   1);
    tick();
    chk("e3_dclk",  o_data_clk,   1);
    tick();
    chk("e4_dclk",  o_data_clk,   0);
    chk("e4_value", o_value,      17);
    tick();
    chk("e5_busy",  o_busy,       1);
    tick();
    chk("e6_busy",  o_busy,       0);
    chk("single_n", cap.size(),   1);
    if (cap.size() > 0) chk("single_v", cap[0], 17);

    // Four back-to-back writes
    repeat (3) tick();
    cap.delete();
    rise_t.delete();
    for (int i = 0; i < 4; i++) begin
      i_wr_valid = 1'b1;
      i_wr_value = vals4[i];
      chk("b4_ready", o_wr_ready, 1);
      tick();
    end
    i_wr_valid = 1'b0;
    repeat (40) tick();
    chk("b4_n", cap.size(), 4);
    for (int i = 0; i < cap.size() && i < 4; i++)
      chk("b4_val", cap[i], vals4[i]);
    for (int i = 1; i < rise_t.size() && i < 4; i++)
      chk("b4_period", 32'(rise_t[i] - rise_t[i-1]), 50);
    chk("b4_idle", o_busy, 0);

    // Six writes, producer holds valid through backpressure
    cap.delete();
    saw_full = 0;
    for (int i = 0; i < 6; i++) begin
      push_wait(vals6[i], st);
      if (st > 0) saw_full = 1;
      if (i == 4) begin
        chk("f6_count", o_fifo_count, 4);
        chk("f6_ready", o_wr_ready,   0);
      end
    end
    chk("f6_stall", saw_full, 1);
    repeat (50) tick();
    chk("f6_n", cap.size(), 6);
    for (int i = 0; i < cap.size() && i < 6; i++)
      chk("f6_val", cap[i], vals6[i]);
    chk("f6_empty", o_fifo_count, 0);

    // Reset while strobe is high with two entries queued
    cap.delete();
    for (int i = 0; i < 3; i++) begin
      i_wr_valid = 1'b1;
      i_wr_value = 5'(9 + i);
      tick();
    end
    i_wr_valid = 1'b0;
    chk("mr_dclk_hi", o_data_clk,   1);
    chk("mr_count",   o_fifo_count, 2);
    rst = 1'b0;
    tick();
    chk("mr_dclk_lo", o_data_clk,   0);
    chk("mr_flush",   o_fifo_count, 0);
    chk("mr_busy",    o_busy,       0);
    rst = 1'b1;
    n0 = cap.size();
    repeat (20) tick();
    chk("mr_n", cap.size(), 1);
    chk("mr_nomore", cap.size() - n0, 0);

`ifdef RA_TX_FILL_EN
    // Fill burst of value 12
    cap.delete();
    ready_hi = 0;
    i_fill = 1'b1;
    i_wr_value = 5'd12;
    tick();
    i_fill = 1'b0;
    i_wr_value = 5'd0;
    while (o_busy && ready_hi < 1000) begin
      if (o_wr_ready) ready_hi++;
      tick();
      if (cap.size() > 20) break;
    end
    chk("fill_ready", ready_hi, 0);
    chk("fill_n", cap.size(), 9);
    for (int i = 0; i < cap.size() && i < 9; i++)
      chk("fill_val", cap[i], 12);
    chk("fill_count", o_fifo_count, 0);
    chk("fill_idle", o_busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
